// File: rtl/hazard5_operand_fetch_if.sv
// Bundle of decode, register-file, writeback and execute signals around the
// Hazard5 operand-fetch stage; master is the fetch stage, slave its environment.
interface hazard5_operand_fetch_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
);
  logic              d_valid;
  logic              d_ready;
  logic [W_ADDR-1:0] d_rs1;
  logic [W_ADDR-1:0] d_rs2;
  logic [W_ADDR-1:0] rf_raddr1;
  logic [W_ADDR-1:0] rf_raddr2;
  logic [W_DATA-1:0] rf_rdata1;
  logic [W_DATA-1:0] rf_rdata2;
  logic              wb_wen;
  logic [W_ADDR-1:0] wb_waddr;
  logic [W_DATA-1:0] wb_wdata;
  logic              e_valid;
  logic              e_ready;
  logic [W_DATA-1:0] e_op1;
  logic [W_DATA-1:0] e_op2;

  modport master (
    input  d_valid, d_rs1, d_rs2, rf_rdata1, rf_rdata2,
    input  wb_wen, wb_waddr, wb_wdata, e_ready,
    output d_ready, rf_raddr1, rf_raddr2, e_valid, e_op1, e_op2
  );

  modport slave (
    output d_valid, d_rs1, d_rs2, rf_rdata1, rf_rdata2,
    output wb_wen, wb_waddr, wb_wdata, e_ready,
    input  d_ready, rf_raddr1, rf_raddr2, e_valid, e_op1, e_op2
  );
endinterface

// File: rtl/hazard5_operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 from a read-old register file and keeps them
// coherent with writeback until execute takes them. Macro HAZARD5_WB_FORWARD_EN
// enables same-cycle writeback forwarding; otherwise a hit costs a one-cycle bubble.
module hazard5_operand_fetch #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard5_operand_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [W_DATA-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic              c1_q, c1_d, c2_q, c2_d;

  logic              busy_s, hit1_s, hit2_s, acc_hit1_s, acc_hit2_s;
  logic              bubble_s, e_valid_s, handoff_s, d_ready_s, accept_s;
  logic [W_DATA-1:0] base1_s, base2_s, fwd1_s, fwd2_s, op1_s, op2_s;

  // Writes to x0 are architecturally void, so they never match a source.
  function automatic logic wb_hit(input logic              wen,
                                  input logic [W_ADDR-1:0] waddr,
                                  input logic [W_ADDR-1:0] raddr);
    return wen && (waddr != {W_ADDR{1'b0}}) && (waddr == raddr);
  endfunction

  assign busy_s     = (state_q != ST_IDLE);
  assign hit1_s     = wb_hit(bus.wb_wen, bus.wb_waddr, rs1_q);
  assign hit2_s     = wb_hit(bus.wb_wen, bus.wb_waddr, rs2_q);
  assign acc_hit1_s = wb_hit(bus.wb_wen, bus.wb_waddr, bus.d_rs1);
  assign acc_hit2_s = wb_hit(bus.wb_wen, bus.wb_waddr, bus.d_rs2);

  // FRESH reads the RF unless the accept-cycle write collided; HELD uses the hold copy.
  assign base1_s = ((state_q == ST_FRESH) && !c1_q) ? bus.rf_rdata1 : hold1_q;
  assign base2_s = ((state_q == ST_FRESH) && !c2_q) ? bus.rf_rdata2 : hold2_q;

`ifdef HAZARD5_WB_FORWARD_EN
  assign fwd1_s   = hit1_s ? bus.wb_wdata : base1_s;
  assign fwd2_s   = hit2_s ? bus.wb_wdata : base2_s;
  assign bubble_s = 1'b0;
`else
  assign fwd1_s   = base1_s;
  assign fwd2_s   = base2_s;
  assign bubble_s = busy_s && (hit1_s || hit2_s);
`endif

  assign op1_s = (!busy_s || (rs1_q == {W_ADDR{1'b0}})) ? {W_DATA{1'b0}} : fwd1_s;
  assign op2_s = (!busy_s || (rs2_q == {W_ADDR{1'b0}})) ? {W_DATA{1'b0}} : fwd2_s;

  assign e_valid_s = busy_s && !bubble_s;
  assign handoff_s = e_valid_s && bus.e_ready;
  assign d_ready_s = !busy_s || handoff_s;
  assign accept_s  = bus.d_valid && d_ready_s;

  assign bus.rf_raddr1 = bus.d_rs1;
  assign bus.rf_raddr2 = bus.d_rs2;
  assign bus.d_ready   = d_ready_s;
  assign bus.e_valid   = e_valid_s;
  assign bus.e_op1     = op1_s;
  assign bus.e_op2     = op2_s;

  // Next-state and operand-tracking logic.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    if (accept_s) begin
      state_d = ST_FRESH;
      rs1_d   = bus.d_rs1;
      rs2_d   = bus.d_rs2;
      c1_d    = acc_hit1_s;
      c2_d    = acc_hit2_s;
      hold1_d = acc_hit1_s ? bus.wb_wdata : hold1_q;
      hold2_d = acc_hit2_s ? bus.wb_wdata : hold2_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FRESH, ST_HELD: begin
          if (handoff_s) begin
            state_d = ST_IDLE;
          end else begin
            // Parking the pair: hold copies follow any writeback to the same source.
            state_d = ST_HELD;
            hold1_d = hit1_s ? bus.wb_wdata : base1_s;
            hold2_d = hit2_s ? bus.wb_wdata : base2_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rs1_q   <= {W_ADDR{1'b0}};
      rs2_q   <= {W_ADDR{1'b0}};
      hold1_q <= {W_DATA{1'b0}};
      hold2_q <= {W_DATA{1'b0}};
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

endmodule

// File: tb/tb_hazard5_operand_fetch.sv
// Bench for hazard5_operand_fetch: directed scenarios plus random traffic, checked
// every cycle against an architectural model (operand == current register value).
module tb_hazard5_operand_fetch;
  localparam int WD = 32;
  localparam int WA = 5;
`ifdef HAZARD5_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard5_operand_fetch_if #(.W_DATA(WD), .W_ADDR(WA)) bus ();
  hazard5_operand_fetch #(.W_DATA(WD), .W_ADDR(WA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Raw register file with x0 writable, so operand zeroing cannot lean on it.
  logic [WD-1:0] rf [0:31];
  always @(posedge clk) begin
    bus.rf_rdata1 <= rf[bus.rf_raddr1];
    bus.rf_rdata2 <= rf[bus.rf_raddr2];
    if (bus.wb_wen) rf[bus.wb_waddr] <= bus.wb_wdata;
  end

  logic          m_pend;
  logic [WA-1:0] m_rs1, m_rs2;

  function automatic logic hit(input logic [WA-1:0] a);
    return bus.wb_wen && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == a);
  endfunction

  function automatic logic [WD-1:0] exp_op(input logic [WA-1:0] a);
    if (a == 5'd0) return 32'd0;
    if (FWD && hit(a)) return bus.wb_wdata;
    return rf[a];
  endfunction

  function automatic logic exp_valid();
    return m_pend && (FWD || !(hit(m_rs1) || hit(m_rs2)));
  endfunction

  function automatic logic exp_ready();
    return !m_pend || (exp_valid() && bus.e_ready);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one pair in flight, kept until execute takes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_rs1  <= 5'd0;
      m_rs2  <= 5'd0;
    end else if (bus.d_valid && exp_ready()) begin
      m_pend <= 1'b1;
      m_rs1  <= bus.d_rs1;
      m_rs2  <= bus.d_rs2;
    end else if (exp_valid() && bus.e_ready) begin
      m_pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_d_ready", {31'd0, bus.d_ready}, {31'd0, exp_ready()});
      check("model_e_valid", {31'd0, bus.e_valid}, {31'd0, exp_valid()});
      if (exp_valid()) begin
        check("model_e_op1", bus.e_op1, exp_op(m_rs1));
        check("model_e_op2", bus.e_op2, exp_op(m_rs2));
      end
    end
  end

  task automatic drv(input logic dv, input logic [4:0] r1, input logic [4:0] r2, input logic er,
                     input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    bus.d_valid  = dv;
    bus.d_rs1    = r1;
    bus.d_rs2    = r2;
    bus.e_ready  = er;
    bus.wb_wen   = wen;
    bus.wb_waddr = wa;
    bus.wb_wdata = wd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  p1 [4];
  logic [4:0]  p2 [4];
  logic [31:0] v1 [4];
  logic [31:0] v2 [4];
  logic [31:0] pre;

  initial begin
    p1 = '{5'd1, 5'd2, 5'd3, 5'd5};
    p2 = '{5'd2, 5'd3, 5'd5, 5'd1};
    v1 = '{32'h11, 32'h22, 32'hDEAD, 32'hBEEF};
    v2 = '{32'h22, 32'hDEAD, 32'hBEEF, 32'h11};
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    // Preload every register while the block sits in reset.
    for (int i = 0; i < 32; i++) begin
      case (i)
        0:       pre = 32'd0;
        1:       pre = 32'h11;
        2:       pre = 32'h22;
        3:       pre = 32'h33;
        5:       pre = 32'h55;
        default: pre = $urandom;
      endcase
      drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, i[4:0], pre);
      next_cyc();
    end
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("rst_e_valid", {31'd0, bus.e_valid}, 32'd0);
    check("rst_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check("rst_e_op1", bus.e_op1, 32'd0);
    check("rst_e_op2", bus.e_op2, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check("post_rst_e_op1", bus.e_op1, 32'd0);
    next_cyc();

    // Plain read.
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk); check("t38_d_ready", {31'd0, bus.d_ready}, 32'd1); next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t38_e_valid", {31'd0, bus.e_valid}, 32'd1);
    check("t38_e_op1", bus.e_op1, 32'h11);
    check("t38_e_op2", bus.e_op2, 32'h22);
    next_cyc();

    // Writeback collides with the accept cycle.
    drv(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 32'hDEAD);
    @(negedge clk); next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t39_e_valid", {31'd0, bus.e_valid}, 32'd1);
    check("t39_e_op1", bus.e_op1, 32'hDEAD);
    check("t39_e_op2", bus.e_op2, 32'h11);
    next_cyc();

    // Stall with a writeback to rs2 while held.
    drv(1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk); next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk); check("t40_fresh_op2", bus.e_op2, 32'h55); next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hBEEF);
    @(negedge clk);
    check("t40_wb_cycle_valid", {31'd0, bus.e_valid}, {31'd0, FWD});
`ifdef HAZARD5_WB_FORWARD_EN
    check("t40_wb_cycle_op2", bus.e_op2, 32'hBEEF);
`endif
    next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t40_held_valid", {31'd0, bus.e_valid}, 32'd1);
    check("t40_held_op1", bus.e_op1, 32'h11);
    check("t40_held_op2", bus.e_op2, 32'hBEEF);
    next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk); check("t40_release_op2", bus.e_op2, 32'hBEEF); next_cyc();

    // x0 stays zero even when the raw RF holds junk there.
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk); next_cyc();
    drv(1'b1, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t41_e_op1", bus.e_op1, 32'd0);
    check("t41_e_op2", bus.e_op2, 32'd0);
    next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t41b_e_op1", bus.e_op1, 32'd0);
    check("t41b_e_op2", bus.e_op2, 32'h11);
    next_cyc();

    // Back-to-back throughput.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drv(1'b1, p1[k], p2[k], 1'b1, 1'b0, 5'd0, 32'd0);
      else       drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t42_d_ready", {31'd0, bus.d_ready}, 32'd1);
      if (k > 0) begin
        check("t42_e_valid", {31'd0, bus.e_valid}, 32'd1);
        check("t42_e_op1", bus.e_op1, v1[k-1]);
        check("t42_e_op2", bus.e_op2, v2[k-1]);
      end
      next_cyc();
    end

    // Reset while a pair is held.
    drv(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk); next_cyc();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk); next_cyc();
    check("t43_pre_valid", {31'd0, bus.e_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t43_e_valid", {31'd0, bus.e_valid}, 32'd0);
    check("t43_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check("t43_e_op1", bus.e_op1, 32'd0);
    check("t43_e_op2", bus.e_op2, 32'd0);
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t43_after_valid", {31'd0, bus.e_valid}, 32'd0);
    next_cyc();

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
          5'($urandom_range(0, 7)), $urandom);
      next_cyc();
    end
    drv(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    next_cyc(); next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
